// File: rtl/mainmem_pkg.sv
// mainmem_pkg: shared widths, latency and request/pipe record types for the main-memory responder.
package mainmem_pkg;
    localparam int MAINMEM_ADDR_WIDTH = 16;
    localparam int MAINMEM_DATA_WIDTH = 16;
    localparam int MAINMEM_INDEX_BITS = 15;
    localparam int MAINMEM_LATENCY = 4;

    typedef struct packed {
        logic                          enable;
        logic                          wr;
        logic [MAINMEM_ADDR_WIDTH-1:0] addr;
        logic [MAINMEM_DATA_WIDTH-1:0] data;
    } mainmem_req_t;

    typedef struct packed {
        logic                          rd_vld;
        logic                          wr_vld;
        logic [MAINMEM_DATA_WIDTH-1:0] data;
    } mainmem_pipe_t;
endpackage

// File: rtl/mainmem_delay_pipe.sv
// mainmem_delay_pipe: LATENCY-stage shift register of pipe records, cleared synchronously on rst.
module mainmem_delay_pipe
    import mainmem_pkg::*;
#(
    parameter int LATENCY = MAINMEM_LATENCY
) (
    input  logic          clk,
    input  logic          rst,
    input  mainmem_pipe_t d,
    output mainmem_pipe_t q
);
    mainmem_pipe_t stage [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '{default: '0};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[LATENCY-1];
endmodule

// File: rtl/mainmem_responder.sv
// mainmem_responder: fixed-latency pipelined word memory behind the cache arbiter.
// Optional MAINMEM_WR_ACK_EN adds a wr_ack strobe LATENCY cycles after each write.
module mainmem_responder
    import mainmem_pkg::*;
#(
    parameter int ADDR_WIDTH = MAINMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MAINMEM_DATA_WIDTH,
    parameter int INDEX_BITS = MAINMEM_INDEX_BITS,
    parameter int LATENCY    = MAINMEM_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
`ifdef MAINMEM_WR_ACK_EN
    ,
    output logic                  wr_ack
`endif
);
    logic [DATA_WIDTH-1:0] mem [2**INDEX_BITS];
    logic [INDEX_BITS-1:0] idx;
    mainmem_pipe_t         pipe_in;
    mainmem_pipe_t         pipe_out;
    logic                  unused_bits;

    // addr[0] and bits above INDEX_BITS are dropped, so addresses alias
    assign idx = addr[INDEX_BITS:1];

    always_ff @(posedge clk) begin
        if (!rst && enable && wr) mem[idx] <= data_in;
    end

    always_comb begin
        pipe_in        = '0;
        pipe_in.rd_vld = enable & ~wr;
        pipe_in.data   = MAINMEM_DATA_WIDTH'(mem[idx]);
`ifdef MAINMEM_WR_ACK_EN
        pipe_in.wr_vld = enable & wr;
`endif
    end

    mainmem_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk (clk),
        .rst (rst),
        .d   (pipe_in),
        .q   (pipe_out)
    );

    assign data_valid = pipe_out.rd_vld;
    assign data_out   = pipe_out.rd_vld ? DATA_WIDTH'(pipe_out.data) : '0;
`ifdef MAINMEM_WR_ACK_EN
    assign wr_ack      = pipe_out.wr_vld;
    assign unused_bits = ^addr;
`else
    assign unused_bits = ^{addr, pipe_out.wr_vld};
`endif
endmodule

// File: tb/tb_mainmem_responder.sv
// tb_mainmem_responder: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_mainmem_responder;
    localparam int LAT = 4;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid;
`ifdef MAINMEM_WR_ACK_EN
    logic        wr_ack;
    int          ack_q[$];
`endif

    exp_t exp_q[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    mainmem_responder #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid)
`ifdef MAINMEM_WR_ACK_EN
        ,
        .wr_ack     (wr_ack)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: every read strobe must match the head of the queue in data and cycle.
    always @(negedge clk) begin
        if (data_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid edge=%0d data_out=%h required no strobe", edge_n, data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_out !== e.data || edge_n != e.due) begin
                    errors++;
                    $display("FAIL read_data edge=%0d data_out=%h required %h at edge %0d", edge_n, data_out, e.data, e.due);
                end
            end
        end else begin
            checks++;
            if (data_out !== 16'h0000) begin
                errors++;
                $display("FAIL idle_data edge=%0d data_out=%h required 0000", edge_n, data_out);
            end
            if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
                checks++;
                errors++;
                $display("FAIL missing_valid edge=%0d data_valid=0 required 1 data %h", edge_n, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
`ifdef MAINMEM_WR_ACK_EN
        checks++;
        if (wr_ack) begin
            if (ack_q.size() == 0 || ack_q[0] != edge_n) begin
                errors++;
                $display("FAIL wr_ack edge=%0d wr_ack=1 required 0", edge_n);
            end
            if (ack_q.size() > 0) void'(ack_q.pop_front());
        end else if (ack_q.size() > 0 && ack_q[0] <= edge_n) begin
            errors++;
            $display("FAIL wr_ack edge=%0d wr_ack=0 required 1", edge_n);
            void'(ack_q.pop_front());
        end
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_req(input logic [15:0] a, input logic [15:0] d);
        enable = 1'b1; wr = 1'b1; addr = a; data_in = d;
`ifdef MAINMEM_WR_ACK_EN
        ack_q.push_back(edge_n + LAT);
`endif
        step();
    endtask

    task automatic rd_req(input logic [15:0] a, input logic [15:0] expect_data);
        enable = 1'b1; wr = 1'b0; addr = a; data_in = 16'hxxxx;
        exp_q.push_back('{edge_n + LAT, expect_data});
        step();
    endtask

    task automatic idle(input int n);
        enable = 1'b0; wr = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        repeat (3) step();
        checks++;
        if (data_valid !== 1'b0 || data_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state data_valid=%b data_out=%h required 0 0000", data_valid, data_out);
        end
        rst = 1'b0;
        idle(2);
        // read-after-write
        wr_req(16'h0010, 16'hBEEF);
        rd_req(16'h0010, 16'hBEEF);
        idle(6);
        // back-to-back reads in order
        wr_req(16'h0020, 16'h1111);
        wr_req(16'h0022, 16'h2222);
        wr_req(16'h0024, 16'h3333);
        rd_req(16'h0020, 16'h1111);
        rd_req(16'h0022, 16'h2222);
        rd_req(16'h0024, 16'h3333);
        idle(6);
        // write-after-read leaves the in-flight read intact
        wr_req(16'h0030, 16'hAAAA);
        idle(1);
        rd_req(16'h0030, 16'hAAAA);
        wr_req(16'h0030, 16'h5555);
        rd_req(16'h0030, 16'h5555);
        idle(6);
        // reset kills in-flight reads and drops the same-cycle request
        wr_req(16'h0050, 16'hCAFE);
        rd_req(16'h0050, 16'hCAFE);
        rd_req(16'h0050, 16'hCAFE);
        exp_q.delete();
        enable = 1'b1; wr = 1'b1; addr = 16'h0050; data_in = 16'hDEAD; rst = 1'b1;
        step();
        rst = 1'b0;
        idle(LAT + 4);
        rd_req(16'h0050, 16'hCAFE);
        rd_req(16'h0024, 16'h3333);
        // byte bit ignored, so odd and even addresses alias
        wr_req(16'h0041, 16'h7777);
        rd_req(16'h0040, 16'h7777);
        wr_req(16'h0000, 16'h0F0F);
        wr_req(16'hFFFF, 16'hF0F0);
        rd_req(16'h0001, 16'h0F0F);
        rd_req(16'hFFFE, 16'hF0F0);
        idle(LAT + 6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
`ifdef MAINMEM_WR_ACK_EN
        checks++;
        if (ack_q.size() != 0) begin
            errors++;
            $display("FAIL ack_drain pending=%0d required 0", ack_q.size());
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mainmem_responder.md
# mainmem_responder

Responder end of the cache-arbiter-to-main-memory interface: a fully pipelined, fixed-latency, word-addressed main memory. It accepts one read or write request per cycle from the cache arbiter and returns read data with a one-cycle `data_valid` strobe exactly `LATENCY` cycles after the request. It sits behind the arbiter at the bottom of the memory hierarchy, beneath both the instruction and data caches.

## Interface
- `ADDR_WIDTH`, default 16: byte-address width.
- `DATA_WIDTH`, default 16: word width.
- `INDEX_BITS`, default 15: word-index bits used; storage is 2^INDEX_BITS words.
- `LATENCY`, default 4: read latency in cycles; legal range 1..8.
- `clk  input  1`: single clock, rising edge.
- `rst  input  1`: synchronous reset, active-high.
- `enable  input  1`: request valid this cycle.
- `wr  input  1`: 1 = write request, 0 = read request; qualified by `enable`.
- `addr  input  ADDR_WIDTH`: byte address.
- `data_in  input  DATA_WIDTH`: write data.
- `data_out  output  DATA_WIDTH`: read data; meaningful only while `data_valid` is high.
- `data_valid  output  1`: one-cycle strobe marking returned read data.
- `wr_ack  output  1`: write-completion strobe. Present only with `MAINMEM_WR_ACK_EN`.

## Operation
- Word index is `addr[INDEX_BITS:1]`.
  - `addr[0]` is ignored.
  - Address bits above `INDEX_BITS` are ignored, so addresses alias modulo 2^(INDEX_BITS+1) bytes.
- No backpressure. A new request is accepted on every edge where `enable` is high.
- **Write** (`enable & wr`): the array word is updated at the accepting edge.
- **Read** (`enable & ~wr`): the array word is sampled at the accepting edge. That word plus a valid bit then enter stage 1 of a `LATENCY`-deep delay pipe.
- Read-after-write: a read accepted at least one cycle after a write to the same word returns the new data.
- Write-after-read: a write accepted after a read has been accepted does not alter that in-flight read's data.
- Reads complete in issue order. Back-to-back reads produce back-to-back `data_valid` strobes.
- `data_out` is the last pipe stage's data when that stage is valid, otherwise 0.
- Reset:
  - Clears all pipe valid bits and `data_out`.
  - A request presented in the same cycle as `rst` is dropped; a write in that cycle does not update the array.
  - Array contents are not cleared. Writes accepted before the reset edge persist.
  - Reset during in-flight reads: no `data_valid` is produced for those reads.

## Timing
- Read accepted at edge T → `data_valid` = 1 and `data_out` = word during the cycle following edge T+LATENCY-1. For `LATENCY` = 4, that is the 4th cycle after the request cycle.
- `data_valid` is high for exactly one cycle per read.
- Write: 1-cycle effect, and no `data_valid`.
- Reset values: `data_out` = 0, `data_valid` = 0, `wr_ack` = 0.
- Throughput is one request per cycle. Reads and writes may interleave freely.

## Configuration
- `MAINMEM_WR_ACK_EN` defined:
  - Writes also travel the delay pipe, with a separate write-valid bit and no data.
  - `wr_ack` pulses high exactly `LATENCY` cycles after the write, with the same timing as a read.
  - `data_valid` stays low for writes.
  - Reset clears pending acks.
- `MAINMEM_WR_ACK_EN` undefined: the `wr_ack` port is absent and the pipe carries read-valid only.

## Structure
- Package `mainmem_pkg`:
  - Default width constants and `MAINMEM_LATENCY`.
  - A `mainmem_req_t` struct {enable, wr, addr, data}.
  - A `mainmem_pipe_t` struct {rd_vld, wr_vld, data}.
- Sub-module `mainmem_delay_pipe`:
  - Parameterized `LATENCY`-stage shift register of `mainmem_pipe_t`.
  - Synchronous clear on `rst`.
- Top module holds the storage array and the request decode.

## Test plan
- Write 0xBEEF to 0x0010 at cycle 0, read 0x0010 at cycle 1 → `data_valid` = 1 with `data_out` = 0xBEEF in cycle 5 only.
- Write 0x1111/0x2222/0x3333 to 0x0020/0x0022/0x0024, then three back-to-back reads → three consecutive `data_valid` cycles returning 0x1111, 0x2222, 0x3333 in order.
- Read 0x0030 (holding 0xAAAA) at cycle 0, write 0x5555 to 0x0030 at cycle 1 → returned data is 0xAAAA; a read at cycle 2 returns 0x5555.
- Issue reads at cycles 0–2, assert `rst` at cycle 2 → no `data_valid` at any later cycle; `data_out` = 0; earlier-written array data still readable afterwards.
- Aliasing: write 0x7777 to 0x0041, read 0x0040 → returns 0x7777.
- With `MAINMEM_WR_ACK_EN`: write at cycle 0 → `wr_ack` high in cycle 4 only, `data_valid` stays low.
